// File: rtl/inst_ram256x8_pkg.sv
// Shared constants and the wrapped byte-index helper for the 256x8 instruction RAM.
package inst_ram256x8_pkg;

    localparam int RAM_DEPTH      = 256;
    localparam int RAM_WORD_BYTES = 4;
    localparam int RAM_ADDR_W     = 8;

    // Byte lane offsets past the top of the array fold back to the bottom.
    function automatic logic [RAM_ADDR_W-1:0] byte_idx(
        input logic [RAM_ADDR_W-1:0] base,
        input logic [1:0]            off
    );
        return base + {6'd0, off};
    endfunction

endpackage

// File: rtl/inst_ram256x8.sv
// Byte-organised instruction RAM: combinational big-endian word read, clocked
// byte preload port and a sticky misaligned/out-of-range read flag.
module inst_ram256x8
    import inst_ram256x8_pkg::*;
#(
    parameter int DEPTH      = RAM_DEPTH,
    parameter int WORD_BYTES = RAM_WORD_BYTES
) (
    output logic [31:0] DataOut,
    input  logic        Enable,
    input  logic [31:0] Address,
    input  logic        clk,
    input  logic        reset,
    input  logic        LoadEn,
    input  logic [7:0]  LoadAddr,
    input  logic [7:0]  LoadData,
    output logic        AddrErr
);

    logic [7:0]  Mem [0:DEPTH-1];
    logic [31:0] data_s;
    logic        bad_addr_s;
    logic        addr_err_r;

    // Big-endian word assembly; the lowest byte address lands in bits 31:24.
    always_comb begin
        data_s = 32'h0000_0000;
        if (Enable) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                data_s[31 - 8*i -: 8] = Mem[byte_idx(Address[RAM_ADDR_W-1:0], i[1:0])];
            end
        end else begin
            data_s = 32'h0000_0000;
        end
    end

    // Flag condition: word not 4-byte aligned or upper address bits set.
    always_comb begin
        bad_addr_s = 1'b0;
        if (Enable) begin
            bad_addr_s = (Address[1:0] != 2'b00) || (Address[31:8] != 24'h00_0000);
        end else begin
            bad_addr_s = 1'b0;
        end
    end

    // Preload write port; contents are deliberately kept across reset.
    always_ff @(posedge clk) begin
        if (!reset && LoadEn) begin
            Mem[LoadAddr] <= LoadData;
        end
    end

    // Sticky address error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err_r <= 1'b0;
        end else if (bad_addr_s) begin
            addr_err_r <= 1'b1;
        end
    end

    assign DataOut = data_s;
    assign AddrErr = addr_err_r;

endmodule

// File: tb/tb_inst_ram256x8.sv
// Directed self-checking bench for inst_ram256x8.
`timescale 1ns/1ps
module tb_inst_ram256x8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] DataOut;
    logic        Enable;
    logic [31:0] Address;
    logic        LoadEn;
    logic [7:0]  LoadAddr;
    logic [7:0]  LoadData;
    logic        AddrErr;

    int checks = 0;
    int errors = 0;

    inst_ram256x8 dut (
        .DataOut (DataOut),
        .Enable  (Enable),
        .Address (Address),
        .clk     (clk),
        .reset   (reset),
        .LoadEn  (LoadEn),
        .LoadAddr(LoadAddr),
        .LoadData(LoadData),
        .AddrErr (AddrErr)
    );

    always #5 clk = ~clk;

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        @(negedge clk);
        LoadEn = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        Enable = 1'b0; Address = 32'h0; LoadEn = 1'b0; LoadAddr = 8'h00; LoadData = 8'h00;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (AddrErr !== 1'b0) begin
            errors++; $display("FAIL reset_addrerr got %b want 0", AddrErr);
        end
        checks++;
        if (DataOut !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_dataout got %h want 00000000", DataOut);
        end
    endtask

    task automatic test_aligned();
        load_byte(8'd0, 8'hE2); load_byte(8'd1, 8'h01);
        load_byte(8'd2, 8'h10); load_byte(8'd3, 8'h05);
        Address = 32'h0; Enable = 1'b1;
        #1;
        checks++;
        if (DataOut !== 32'hE201_1005) begin
            errors++; $display("FAIL aligned_data got %h want e2011005", DataOut);
        end
        @(posedge clk); #1;
        checks++;
        if (AddrErr !== 1'b0) begin
            errors++; $display("FAIL aligned_addrerr got %b want 0", AddrErr);
        end
        Enable = 1'b0;
    endtask

    task automatic test_disable();
        logic [31:0] addrs [3] = '{32'h0, 32'h0000_00FE, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            Enable = 1'b0; Address = addrs[i];
            #1;
            checks++;
            if (DataOut !== 32'h0000_0000) begin
                errors++; $display("FAIL disable_%0d got %h want 00000000", i, DataOut);
            end
        end
    endtask

    task automatic test_wrap();
        load_byte(8'd254, 8'hAA); load_byte(8'd255, 8'hBB);
        load_byte(8'd0, 8'hCC);   load_byte(8'd1, 8'hDD);
        Address = 32'h0000_00FE; Enable = 1'b1;
        #1;
        checks++;
        if (DataOut !== 32'hAABB_CCDD) begin
            errors++; $display("FAIL wrap_data got %h want aabbccdd", DataOut);
        end
        checks++;
        if (AddrErr !== 1'b0) begin
            errors++; $display("FAIL wrap_preedge got %b want 0", AddrErr);
        end
        @(posedge clk); #1;
        checks++;
        if (AddrErr !== 1'b1) begin
            errors++; $display("FAIL wrap_addrerr got %b want 1", AddrErr);
        end
        Enable = 1'b0;
    endtask

    task automatic test_oor_reset();
        pulse_reset();
        #1;
        checks++;
        if (AddrErr !== 1'b0) begin
            errors++; $display("FAIL oor_cleared got %b want 0", AddrErr);
        end
        load_byte(8'd4, 8'h11); load_byte(8'd5, 8'h22);
        load_byte(8'd6, 8'h33); load_byte(8'd7, 8'h44);
        Address = 32'h0000_0104; Enable = 1'b1;
        #1;
        checks++;
        if (DataOut !== 32'h1122_3344) begin
            errors++; $display("FAIL oor_data got %h want 11223344", DataOut);
        end
        @(posedge clk); #1;
        checks++;
        if (AddrErr !== 1'b1) begin
            errors++; $display("FAIL oor_addrerr got %b want 1", AddrErr);
        end
        Enable = 1'b0;
        pulse_reset();
        #1;
        checks++;
        if (AddrErr !== 1'b0) begin
            errors++; $display("FAIL oor_reset got %b want 0", AddrErr);
        end
        Address = 32'h0000_0004; Enable = 1'b1;
        #1;
        checks++;
        if (DataOut !== 32'h1122_3344) begin
            errors++; $display("FAIL mem_survives_reset got %h want 11223344", DataOut);
        end
        Enable = 1'b0;
    endtask

    task automatic test_preload();
        load_byte(8'h08, 8'h7F);
        Address = 32'h0000_0008; Enable = 1'b1;
        #1;
        checks++;
        if (DataOut[31:24] !== 8'h7F) begin
            errors++; $display("FAIL preload got %h want 7f", DataOut[31:24]);
        end
        @(negedge clk);
        LoadEn = 1'b1; LoadAddr = 8'h08; LoadData = 8'h5A;
        #1;
        checks++;
        if (DataOut[31:24] !== 8'h7F) begin
            errors++; $display("FAIL same_cycle_old got %h want 7f", DataOut[31:24]);
        end
        @(posedge clk); #1;
        LoadEn = 1'b0;
        checks++;
        if (DataOut[31:24] !== 8'h5A) begin
            errors++; $display("FAIL same_cycle_new got %h want 5a", DataOut[31:24]);
        end
        Enable = 1'b0;
    endtask

    task automatic test_loaden_in_reset();
        load_byte(8'h09, 8'h3C);
        @(negedge clk);
        reset = 1'b1; LoadEn = 1'b1; LoadAddr = 8'h09; LoadData = 8'h99;
        @(negedge clk);
        reset = 1'b0; LoadEn = 1'b0;
        Address = 32'h0000_0008; Enable = 1'b1;
        #1;
        checks++;
        if (DataOut[23:16] !== 8'h3C) begin
            errors++; $display("FAIL loaden_in_reset got %h want 3c", DataOut[23:16]);
        end
        Enable = 1'b0;
    endtask

    task automatic test_sweep();
        logic [7:0]  b [36];
        logic [31:0] exp_w;
        for (int i = 0; i < 36; i++) begin
            b[i] = 8'(i * 7 + 3);
            load_byte(8'(i), b[i]);
        end
        pulse_reset();
        for (int a = 0; a <= 32; a += 4) begin
            Address = 32'(a);
            exp_w = {b[a], b[a+1], b[a+2], b[a+3]};
            Enable = 1'b1;
            #1;
            checks++;
            if (DataOut !== exp_w) begin
                errors++; $display("FAIL sweep_%0d got %h want %h", a, DataOut, exp_w);
            end
            #4 Enable = 1'b0;
            #1;
            checks++;
            if (DataOut !== 32'h0000_0000) begin
                errors++; $display("FAIL sweep_off_%0d got %h want 00000000", a, DataOut);
            end
            #4;
        end
        @(posedge clk); #1;
        checks++;
        if (AddrErr !== 1'b0) begin
            errors++; $display("FAIL sweep_addrerr got %b want 0", AddrErr);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_disable();
        test_wrap();
        test_oor_reset();
        test_preload();
        test_loaden_in_reset();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_ram256x8.md
INST_RAM256X8 -- requirements
Module: inst_ram256x8

Interface
REQ-001 Parameter list: DEPTH, 256, number of byte locations. WORD_BYTES, 4, bytes per instruction word; fixed at 4.
REQ-002 Port list, one per line:
- clk  input  1  single system clock.
- reset  input  1  synchronous, active-high reset.
- DataOut  output  32  instruction word read.
- Enable  input  1  read enable.
- Address  input  32  byte address of the word's first byte.
- LoadEn  input  1  byte preload write strobe.
- LoadAddr  input  8  preload byte address.
- LoadData  input  8  preload byte value.
- AddrErr  output  1  sticky flag for a misaligned or out-of-range read.
REQ-003 Port order for positional instantiation: DataOut, Enable, Address first; then clk, reset, LoadEn, LoadAddr, LoadData, AddrErr.
REQ-004 Storage: an 8-bit array named Mem, indexed 0..DEPTH-1. It shall be writable by hierarchical reference (ram.Mem[i] = byte) so that benches can preload it without a clock.

Function
REQ-005 Read path: combinational, zero clock latency.
- Enable=1: DataOut = {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}, where A = Address[7:0] (big-endian, lowest address in bits 31:24).
- Enable=0: DataOut = 32'h0000_0000.
REQ-006 Byte indices A+1..A+3 are computed modulo 256; a read at A=8'hFE returns {Mem[254], Mem[255], Mem[0], Mem[1]}.
REQ-007 Address[31:8] is ignored for data selection.
REQ-008 DataOut responds to any change of Enable, Address or Mem contents within the same delta cycle; it is valid well before 1 time unit after the Enable edge.
REQ-009 Preload write: on the rising clk edge with LoadEn=1, Mem[LoadAddr] <= LoadData.
REQ-010 A preload write and a read of the same byte in the same cycle: the read returns the old byte before the edge and the new byte after it.
REQ-011 AddrErr is set at a rising clk edge when Enable=1 and either Address[1:0]!=0 or Address[31:8]!=0.
REQ-012 Once set, AddrErr stays set until reset.
REQ-013 A misaligned or out-of-range read still returns data per REQ-005 and REQ-006; the flag is informational only.
REQ-014 LoadEn is ignored while reset=1.
REQ-015 The array has no read-modify-write behaviour and no other write path.

Reset
REQ-016 Synchronous, active-high: at a rising clk edge with reset=1, AddrErr <= 0.
REQ-017 Reset does not clear Mem; preloaded contents survive reset.
REQ-018 DataOut is combinational and not affected by reset.
REQ-019 Mem is uninitialised (X) at time 0 until preloaded.

Structure
REQ-020 A shared package holds DEPTH, WORD_BYTES and the address width constant (8).
REQ-021 The block is a single module with no sub-modules.
REQ-022 A natural partition is an optional helper function for wrapped byte-index computation.

Verification
REQ-023 Bench preloads Mem by hierarchical byte writes read with $fscanf "%b" from a text file, then steps Address 0,4,...,32 with Enable pulses (5 units high, 5 low). It samples DataOut 1 unit after each Enable rise.
REQ-024 Aligned read: Mem[0..3] = 8'hE2,8'h01,8'h10,8'h05; Enable=1, Address=0 -> DataOut=32'hE2011005 and AddrErr stays 0 after the next clk.
REQ-025 Disable: Enable=0 with any Address -> DataOut=32'h00000000.
REQ-026 Wrap: Mem[254..255] = 8'hAA,8'hBB and Mem[0..1] = 8'hCC,8'hDD; Address=32'h000000FE, Enable=1 -> DataOut=32'hAABBCCDD, and AddrErr=1 after the next clk edge (misaligned).
REQ-027 Out-of-range and reset: Address=32'h00000104 with Mem[4..7] = 8'h11,8'h22,8'h33,8'h44 -> DataOut=32'h11223344 and AddrErr=1 after the clk edge. Then reset=1 for one clk -> AddrErr=0 and Mem[4] still 8'h11.
REQ-028 Preload port: LoadEn=1, LoadAddr=8'h08, LoadData=8'h7F for one clk; then Address=8, Enable=1 -> DataOut[31:24]=8'h7F.
